// File: rtl/motor_loop_axil_sequencer.sv
// AXI4-Lite master running a fixed-period proportional loop: read encoder count,
// compute saturated duty from setpoint error, write it to the PWM register.
module motor_loop_axil_sequencer #(
    parameter int unsigned            ADDR_WIDTH    = 4,
    parameter int unsigned            PERIOD_CYCLES = 100000,
    parameter logic [ADDR_WIDTH-1:0]  ENC_ADDR      = ADDR_WIDTH'(4'h4),
    parameter logic [ADDR_WIDTH-1:0]  PWM_ADDR      = ADDR_WIDTH'(4'h8),
    parameter int unsigned            KP_SHIFT      = 4,
    parameter int unsigned            DUTY_MAX      = 1000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    input  logic [31:0]           setpoint,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [31:0]           last_count,
    output logic [31:0]           duty,
    output logic                  busy,
    output logic                  bus_err,
    output logic [15:0]           overrun_cnt
);

    localparam int unsigned        CNT_W      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic signed [32:0] DUTY_MAX_S = 33'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_COMPUTE, S_WR, S_WR_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               enable_q, enable_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [31:0]        last_count_q, last_count_d;
    logic [31:0]        duty_q, duty_d;
    logic               bus_err_q, bus_err_d;
    logic [15:0]        overrun_q, overrun_d;

    logic               tick;
    logic               aw_left, w_left;
    logic signed [32:0] err_s, shifted_s;
    logic [31:0]        duty_calc;

    always_comb begin
        tick  = enable && (cnt_q == CNT_LAST);
        cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;

        // Error widened to 33 bits so setpoint - count never wraps
        err_s     = $signed({setpoint[31], setpoint}) - $signed({last_count_q[31], last_count_q});
        shifted_s = err_s >>> KP_SHIFT;
        if (shifted_s[32])
            duty_calc = '0;
        else if (shifted_s > DUTY_MAX_S)
            duty_calc = 32'(DUTY_MAX);
        else
            duty_calc = shifted_s[31:0];

        aw_left = awvalid_q && !m_axi_awready;
        w_left  = wvalid_q && !m_axi_wready;

        state_d      = state_q;
        enable_d     = enable;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        last_count_d = last_count_q;
        duty_d       = duty_q;
        bus_err_d    = (enable && !enable_q) ? 1'b0 : bus_err_q;
        overrun_d    = overrun_q;

        if (tick && state_q != S_IDLE && overrun_q != '1)
            overrun_d = overrun_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d   = S_RD_ADDR;
                    arvalid_d = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = S_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi_rresp != 2'b00) begin
                        bus_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        last_count_d = m_axi_rdata;
                        state_d      = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                duty_d    = duty_calc;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = S_WR;
            end
            S_WR: begin
                // AW and W retire independently; move on once neither is outstanding
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != 2'b00)
                        bus_err_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            enable_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            last_count_q <= '0;
            duty_q       <= '0;
            bus_err_q    <= 1'b0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enable_q     <= enable_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            last_count_q <= last_count_d;
            duty_q       <= duty_d;
            bus_err_q    <= bus_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_axi_araddr  = ENC_ADDR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_awaddr  = PWM_ADDR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = duty_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign last_count    = last_count_q;
    assign duty          = duty_q;
    assign busy          = (state_q != S_IDLE);
    assign bus_err       = bus_err_q;
    assign overrun_cnt   = overrun_q;

endmodule

// File: tb/tb_motor_loop_axil_sequencer.sv
// Directed bench for motor_loop_axil_sequencer against a small configurable AXI4-Lite slave.
module tb_motor_loop_axil_sequencer;

    localparam int unsigned P = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] setpoint;
    logic [3:0]  araddr, awaddr;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] rdata, wdata, last_count, duty;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    logic        busy, bus_err;
    logic [15:0] overrun_cnt;

    // Slave controls and observations
    logic [31:0] enc;
    logic        r_stall;
    logic [1:0]  rresp_v;
    int          aw_delay;
    int          aw_wait;
    logic        r_pend, aw_got, w_got;
    int          ar_count = 0, aw_count = 0, w_count = 0, b_count = 0;
    logic [3:0]  last_araddr = '0, last_awaddr = '0, last_wstrb = '0;
    logic [31:0] last_wdata = '0;

    // Negedge monitor
    int   cyc = 0, awv_cyc = 0, wv_cyc = 0, ar_rise = 0, aw_rise = 0;
    logic arvalid_prev = 1'b0, awvalid_prev = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    motor_loop_axil_sequencer #(
        .ADDR_WIDTH    (4),
        .PERIOD_CYCLES (P),
        .ENC_ADDR      (4'h4),
        .PWM_ADDR      (4'h8),
        .KP_SHIFT      (4),
        .DUTY_MAX      (1000)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .enable        (enable),
        .setpoint      (setpoint),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .last_count    (last_count),
        .duty          (duty),
        .busy          (busy),
        .bus_err       (bus_err),
        .overrun_cnt   (overrun_cnt)
    );

    assign arready = 1'b1;
    assign wready  = 1'b1;
    assign rdata   = enc;
    assign rresp   = rresp_v;
    assign bresp   = 2'b00;
    assign awready = (aw_wait + 1 >= aw_delay);

    always @(posedge clk) begin
        if (rst) begin
            rvalid  <= 1'b0;
            r_pend  <= 1'b0;
            bvalid  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_wait <= 0;
        end else begin
            if (arvalid && arready) begin
                ar_count    <= ar_count + 1;
                last_araddr <= araddr;
                if (r_stall) r_pend <= 1'b1;
                else         rvalid <= 1'b1;
            end
            if (r_pend && !r_stall) begin
                rvalid <= 1'b1;
                r_pend <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) begin
                aw_count    <= aw_count + 1;
                aw_got      <= 1'b1;
                aw_wait     <= 0;
                last_awaddr <= awaddr;
            end else if (awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (wvalid && wready) begin
                w_count    <= w_count + 1;
                w_got      <= 1'b1;
                last_wdata <= wdata;
                last_wstrb <= wstrb;
            end
            if (aw_got && w_got) begin
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid  <= 1'b0;
                b_count <= b_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        cyc     = cyc + 1;
        awv_cyc = awv_cyc + int'(awvalid);
        wv_cyc  = wv_cyc + int'(wvalid);
        if (arvalid && !arvalid_prev) ar_rise = cyc;
        if (awvalid && !awvalid_prev) aw_rise = cyc;
        arvalid_prev = arvalid;
        awvalid_prev = awvalid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    endtask

    task automatic wait_b(input int target, input string tag);
        int n = 0;
        while (b_count < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(b_count >= target), 32'd1);
    endtask

    task automatic wait_ar(input int target, input string tag);
        int n = 0;
        while (ar_count < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ar_count >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int a, a2, aw0, awc0, wvc0, n;
        rst = 1'b1; enable = 1'b0; setpoint = '0; enc = '0;
        r_stall = 1'b0; rresp_v = 2'b00; aw_delay = 0;
        repeat (3) @(negedge clk);

        check("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("rst_count", last_count, 32'd0);
        check("rst_duty", duty, 32'd0);
        check("rst_flags", 32'({busy, bus_err}), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // (1000 - 200) >>> 4 = 50
        setpoint = 32'd1000; enc = 32'd200; enable = 1'b1;
        wait_b(1, "t1_b_timeout");
        wait_idle("t1_idle_timeout");
        check("t1_araddr", 32'(last_araddr), 32'h4);
        check("t1_awaddr", 32'(last_awaddr), 32'h8);
        check("t1_wdata", last_wdata, 32'd50);
        check("t1_wstrb", 32'(last_wstrb), 32'hF);
        check("t1_duty", duty, 32'd50);
        check("t1_count", last_count, 32'd200);
        check("t1_latency", 32'(aw_rise - ar_rise), 32'd3);

        // 40000 >>> 4 = 2500, clipped to DUTY_MAX
        setpoint = 32'd0; enc = 32'(-40000);
        wait_b(2, "t2_b_timeout");
        check("t2_wdata_sat_hi", last_wdata, 32'd1000);
        check("t2_duty", duty, 32'd1000);

        // negative error clips to 0
        enc = 32'd5000;
        wait_b(3, "t3_b_timeout");
        check("t3_wdata_sat_lo", last_wdata, 32'd0);
        check("t3_count", last_count, 32'd5000);

        // AWREADY late, WREADY immediate
        setpoint = 32'd1000; enc = 32'd200; aw_delay = 5;
        awc0 = awv_cyc; wvc0 = wv_cyc;
        wait_b(4, "t4_b_timeout");
        wait_idle("t4_idle_timeout");
        repeat (3) @(negedge clk);
        check("t4_awvalid_cycles", 32'(awv_cyc - awc0), 32'd5);
        check("t4_wvalid_cycles", 32'(wv_cyc - wvc0), 32'd1);
        check("t4_b_count", 32'(b_count), 32'd4);
        check("t4_aw_count", 32'(aw_count), 32'd4);
        check("t4_wdata", last_wdata, 32'd50);

        // Read data stalled past one period
        aw_delay = 0; r_stall = 1'b1;
        a = ar_count;
        wait_ar(a + 1, "t5_ar_timeout");
        repeat (20) @(negedge clk);
        r_stall = 1'b0;
        wait_b(5, "t5_b_timeout");
        wait_idle("t5_idle_timeout");
        check("t5_overrun", 32'(overrun_cnt), 32'd1);
        check("t5_single_ar", 32'(ar_count), 32'(a + 1));

        // Read error: no write, sticky flag, next tick still runs
        rresp_v = 2'b10; enc = 32'd777;
        a = ar_count; aw0 = aw_count;
        wait_ar(a + 1, "t6_ar_timeout");
        wait_idle("t6_idle_timeout");
        check("t6_bus_err", 32'(bus_err), 32'd1);
        check("t6_no_aw", 32'(aw_count), 32'(aw0));
        check("t6_count_kept", last_count, 32'd200);
        rresp_v = 2'b00;
        wait_b(6, "t6_b_timeout");
        wait_idle("t6b_idle_timeout");
        check("t6_err_sticky", 32'(bus_err), 32'd1);
        check("t6_count_new", last_count, 32'd777);
        check("t6_wdata", last_wdata, 32'd13);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("t6_err_cleared", 32'(bus_err), 32'd0);

        // Drop enable while waiting for read data; (1000 - 520) >>> 4 = 30
        setpoint = 32'd1000; enc = 32'd520; r_stall = 1'b1;
        a = ar_count;
        wait_ar(a + 1, "t7_ar_timeout");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        r_stall = 1'b0;
        wait_b(7, "t7_b_timeout");
        wait_idle("t7_idle_timeout");
        check("t7_wdata", last_wdata, 32'd30);
        check("t7_duty", duty, 32'd30);
        a2 = ar_count;
        repeat (3 * P) @(negedge clk);
        check("t7_no_new_ar", 32'(ar_count), 32'(a2));
        check("t7_busy", 32'(busy), 32'd0);

        // Reset while AWVALID is held
        enable = 1'b1; aw_delay = 5;
        n = 0;
        while (!awvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t8_aw_timeout", 32'(awvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t8_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("t8_overrun", 32'(overrun_cnt), 32'd0);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_duty", duty, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
